i2c_burst_sequencer: RTL
========================

Name: i2c_burst_sequencer

Overview:
Upstream command sequencer for i2c_master. It accepts one burst command (slave address, start register, direction, length) over a valid/ready port. It then drives the master's start/stb/rw/reg_addr/datain handshake byte by byte. Write bytes are pulled from a streaming port, and read bytes are returned on a valid-pulse port. Host logic issues whole bursts without hand-sequencing per-byte strobes.

Parameters:
LEN_W, 5, width of burst length (matches master length port); legal lengths 0..2^LEN_W-1
TIMEOUT_CYC, 1000000, watchdog limit in clk cycles per byte wait (used only with the optional feature)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  high only in IDLE
cmd_rw  in  1  0=write burst, 1=read burst
cmd_len  in  LEN_W  byte count
cmd_slave_addr  in  8  8-bit slave address (R/W bit position ignored by master)
cmd_reg_addr  in  8  first register address
wr_valid  in  1  write byte available
wr_ready  out  1  write byte consumed this cycle
wr_data  in  8  write byte
rd_valid  out  1  one-cycle pulse, read byte valid; no backpressure
rd_data  out  8  read byte
rd_last  out  1  qualifies rd_valid on final byte of burst
busy  out  1  high whenever state != IDLE
cmd_done  out  1  one-cycle pulse at burst completion
err  out  1  sticky timeout flag, cleared on next command accept (optional feature)
m_start, m_stb, m_rw  out  1 each  to i2c_master
m_length  out  LEN_W  to i2c_master
m_slave_address, m_reg_addr, m_datain  out  8 each  to i2c_master
m_dataout  in  8  from i2c_master
m_done  in  1  level from i2c_master, high per completed byte

Behaviour:
- Reset: all outputs 0; state IDLE; byte index 0. Reset mid-burst abandons the burst next edge with no cmd_done. m_start/m_stb must drop the same edge.
- Command accept at cmd_valid & cmd_ready: latch rw, len, slave_addr, reg_addr; index=0.
- cmd_len==0: go directly to FIN; no m_start, no bytes; cmd_done pulses.
- States: IDLE -> START (m_start=1, exactly one cycle) -> GAP (one idle cycle) -> LOAD -> STB -> WAIT_DONE -> WAIT_NDONE -> LOAD (next byte) or FIN -> IDLE.
- LOAD, write burst: wr_ready=1 until wr_valid. On handshake, register m_datain=wr_data and go to STB. A stalled wr_valid stalls indefinitely; it is not a timeout.
- LOAD, read burst: passes straight to STB in one cycle.
- STB: m_stb=1 for exactly one cycle. m_reg_addr = latched reg_addr + index (mod 256, wraps FF->00). m_rw, m_length, m_slave_address are held stable from accept to FIN.
- WAIT_DONE: wait for m_done==1. In that cycle, for reads, register rd_data=m_dataout and pulse rd_valid next cycle. rd_last=1 when index==len-1.
- WAIT_NDONE: wait for m_done==0, then index+1. If index+1==len go to FIN, else LOAD.
- FIN: cmd_done=1 for one cycle; cmd_ready returns next cycle.
- m_done already high on entry to WAIT_DONE (stale level) is not accepted. The prior byte's WAIT_NDONE guarantees it was low.
- cmd_valid while busy is ignored (cmd_ready=0).

Optional Feature:
I2C_SEQ_TIMEOUT_EN: compiles in a cycle counter reset on entry to WAIT_DONE/WAIT_NDONE. If the counter reaches TIMEOUT_CYC, set err=1 and go to FIN; cmd_done pulses and remaining bytes are dropped. Without the macro, the waits are unbounded and err is tied 0.

Decomposition:
- Package i2c_seq_pkg: state enum encoding, LEN_W default, rw constants (I2C_WR=0, I2C_RD=1).
- Sub-module i2c_seq_watchdog (counter + compare), instantiated only under I2C_SEQ_TIMEOUT_EN.

Test Plan:
- Write burst: slave A0, reg 10, len 5, data 11..55. Expect exactly one m_start, five m_stb, and m_reg_addr 10,11,12,13,14 paired with m_datain 11..55. Expect one cmd_done; EEPROM model reads back 11..55.
- Read burst: same addresses, len 5. Expect five rd_valid with rd_data 11,22,33,44,55, rd_last only on 55, then cmd_done.
- Wrap: reg FE, len 4, write. Expect m_reg_addr FE,FF,00,01.
- Edge cases: len 0 -> cmd_done one cycle after accept, no m_start. wr_valid held low 200 cycles in LOAD -> no m_stb until wr_valid.
- Reset mid-burst: assert rst during WAIT_DONE of byte 3. Expect all outputs 0 next edge, no cmd_done. A new command then completes normally.
- With I2C_SEQ_TIMEOUT_EN and TIMEOUT_CYC=100, m_done held 0: expect err=1 and cmd_done at cycle 100 of the wait. err clears on the next accept.

Source files
------------

// File: rtl/i2c_seq_pkg.sv
// Shared types and constants for the i2c burst sequencer.
// Holds the FSM state encoding, the default length width and the direction codes.
package i2c_seq_pkg;

    localparam int LEN_W_DEF = 5;

    localparam logic I2C_WR = 1'b0;
    localparam logic I2C_RD = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_START      = 3'd1,
        ST_GAP        = 3'd2,
        ST_LOAD       = 3'd3,
        ST_STB        = 3'd4,
        ST_WAIT_DONE  = 3'd5,
        ST_WAIT_NDONE = 3'd6,
        ST_FIN        = 3'd7
    } seq_state_t;

endpackage

// File: rtl/i2c_seq_watchdog.sv
// Per-wait cycle counter; expired is asserted on the TIMEOUT_CYC-th cycle of a wait.
// Latency: combinational compare on a registered count; no backpressure.
module i2c_seq_watchdog #(
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic run,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            cnt <= '0;
        end else if (run && !expired) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expired = run && (cnt == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/i2c_burst_sequencer.sv
// Burst command sequencer for i2c_master: one command in, per-byte start/stb handshakes out.
// Latency: START+GAP before first byte, cmd_done one cycle after last byte; write stream stalls in LOAD.
// Optional watchdog on the m_done waits under `I2C_SEQ_TIMEOUT_EN (err tied 0 otherwise).
module i2c_burst_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF
`ifdef I2C_SEQ_TIMEOUT_EN
    , parameter int TIMEOUT_CYC = 1000000
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_rw,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [7:0]       cmd_slave_addr,
    input  logic [7:0]       cmd_reg_addr,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [7:0]       wr_data,
    output logic             rd_valid,
    output logic [7:0]       rd_data,
    output logic             rd_last,
    output logic             busy,
    output logic             cmd_done,
    output logic             err,
    output logic             m_start,
    output logic             m_stb,
    output logic             m_rw,
    output logic [LEN_W-1:0] m_length,
    output logic [7:0]       m_slave_address,
    output logic [7:0]       m_reg_addr,
    output logic [7:0]       m_datain,
    input  logic [7:0]       m_dataout,
    input  logic             m_done
);

    seq_state_t       state, state_nxt;
    logic [LEN_W-1:0] idx;
    logic [LEN_W-1:0] idx_inc;
    logic [7:0]       reg_q;
    logic             accept;
    logic             in_wait;
    logic             wd_expired;
    logic             timeout_hit;

    assign cmd_ready   = (state == ST_IDLE) && !rst;
    assign accept      = cmd_valid && cmd_ready;
    assign busy        = (state != ST_IDLE);
    assign idx_inc     = idx + LEN_W'(1);
    assign m_reg_addr  = reg_q + 8'(idx);
    assign in_wait     = (state == ST_WAIT_DONE) || (state == ST_WAIT_NDONE);
    // A wait only times out if the level it is waiting for did not arrive this cycle.
    assign timeout_hit = wd_expired && ((state == ST_WAIT_DONE) ? !m_done : m_done);

`ifdef I2C_SEQ_TIMEOUT_EN
    i2c_seq_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .restart (state_nxt != state),
        .run     (in_wait),
        .expired (wd_expired)
    );

    always_ff @(posedge clk) begin
        if (rst || accept) begin
            err <= 1'b0;
        end else if (timeout_hit) begin
            err <= 1'b1;
        end
    end
`else
    assign wd_expired = 1'b0;
    assign err        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        m_start   = 1'b0;
        m_stb     = 1'b0;
        wr_ready  = 1'b0;
        cmd_done  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_nxt = (cmd_len == '0) ? ST_FIN : ST_START;
                end
            end
            ST_START: begin
                m_start   = 1'b1;
                state_nxt = ST_GAP;
            end
            ST_GAP: state_nxt = ST_LOAD;
            ST_LOAD: begin
                if (m_rw == I2C_RD) begin
                    state_nxt = ST_STB;
                end else begin
                    wr_ready = 1'b1;
                    if (wr_valid) begin
                        state_nxt = ST_STB;
                    end
                end
            end
            ST_STB: begin
                m_stb     = 1'b1;
                state_nxt = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (m_done) begin
                    state_nxt = ST_WAIT_NDONE;
                end else if (timeout_hit) begin
                    state_nxt = ST_FIN;
                end
            end
            ST_WAIT_NDONE: begin
                if (!m_done) begin
                    state_nxt = (idx_inc == m_length) ? ST_FIN : ST_LOAD;
                end else if (timeout_hit) begin
                    state_nxt = ST_FIN;
                end
            end
            ST_FIN: begin
                cmd_done  = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_rw            <= 1'b0;
            m_length        <= '0;
            m_slave_address <= '0;
            m_datain        <= '0;
            reg_q           <= '0;
            idx             <= '0;
            rd_valid        <= 1'b0;
            rd_last         <= 1'b0;
            rd_data         <= '0;
        end else begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            if (accept) begin
                m_rw            <= cmd_rw;
                m_length        <= cmd_len;
                m_slave_address <= cmd_slave_addr;
                reg_q           <= cmd_reg_addr;
                idx             <= '0;
            end
            if (wr_ready && wr_valid) begin
                m_datain <= wr_data;
            end
            if ((state == ST_WAIT_DONE) && m_done && (m_rw == I2C_RD)) begin
                rd_data  <= m_dataout;
                rd_valid <= 1'b1;
                rd_last  <= (idx_inc == m_length);
            end
            if ((state == ST_WAIT_NDONE) && !m_done) begin
                idx <= idx_inc;
            end
        end
    end

endmodule
